// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares one single-port data memory between the CPU load/store unit (port 0)
// and a DMA/debug master (port 1). Round-robin arbitration, req/ack handshake,
// registered memory-side drive, and legality checking (address window and
// write byte-enable pattern) with an error flag that qualifies the ack.
//
// Optional build macro: DMEM_ARB_STATS_EN adds saturating grant/error counters.
//
// Ports:
//   clk, rst_                  system clock, async active-low reset
//   req0/1, rw0_/1_            request and direction (1=read, 0=write) per port
//   addr0/1, wdata0/1, be0/1   transaction fields, stable while req is held
//   ack0/1                     one-cycle completion pulse per port
//   rdata_o, err_o             read data / illegal-access flag, valid with ack
//   mem_addr, mem_wdata,
//   mem_rw_, mem_byte_en       registered drive to the memory
//   mem_rdata                  combinational read data from the memory
//   gnt_cnt0/1, err_cnt        (DMEM_ARB_STATS_EN only) saturating counters
//
// state  | meaning
// IDLE   | arbitrate; latch the winner into the mem_* registers
// ACCESS | memory driven with latched transaction; legal write commits here
// RESP   | ack/err_o/rdata_o presented for one cycle; requests ignored

module dmem_arbiter #(
   parameter int unsigned WORDS     = 1024,
   parameter int unsigned BITS      = 32,
   parameter logic [31:0] BASE_ADDR = 32'h1000
) (
   input  logic            clk,
   input  logic            rst_,
   input  logic            req0,
   input  logic            req1,
   input  logic            rw0_,
   input  logic            rw1_,
   input  logic [BITS-1:0] addr0,
   input  logic [BITS-1:0] addr1,
   input  logic [BITS-1:0] wdata0,
   input  logic [BITS-1:0] wdata1,
   input  logic [3:0]      be0,
   input  logic [3:0]      be1,
   output logic            ack0,
   output logic            ack1,
   output logic [BITS-1:0] rdata_o,
   output logic            err_o,
   output logic [BITS-1:0] mem_addr,
   output logic [BITS-1:0] mem_wdata,
   output logic            mem_rw_,
   output logic [3:0]      mem_byte_en,
`ifdef DMEM_ARB_STATS_EN
   output logic [15:0]     gnt_cnt0,
   output logic [15:0]     gnt_cnt1,
   output logic [7:0]      err_cnt,
`endif
   input  logic [BITS-1:0] mem_rdata
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCESS = 2'd1;
   localparam logic [1:0] RESP   = 2'd2;

   localparam logic [BITS-1:0] ADDR_LO = BITS'(BASE_ADDR);
   localparam logic [BITS-1:0] ADDR_HI = BITS'(BASE_ADDR + WORDS);

   logic [1:0]      state;
   logic            grant;
   logic            ptr;
   logic            err_flag;

   logic            sel;
   logic            sel_rw_;
   logic [BITS-1:0] sel_addr;
   logic [BITS-1:0] sel_wdata;
   logic [3:0]      sel_be;
   logic            in_range;
   logic            be_ok;
   logic            legal;
   logic            any_req;

   assign any_req = req0 | req1;
   // Lone requester wins outright; the pointer only breaks ties.
   assign sel     = (req0 & req1) ? ptr : req1;

   always_comb begin
      sel_rw_   = rw0_;
      sel_addr  = addr0;
      sel_wdata = wdata0;
      sel_be    = be0;
      if (sel) begin
         sel_rw_   = rw1_;
         sel_addr  = addr1;
         sel_wdata = wdata1;
         sel_be    = be1;
      end
   end

   assign in_range = (sel_addr >= ADDR_LO) && (sel_addr < ADDR_HI);
   assign be_ok    = (sel_be == 4'b0001) || (sel_be == 4'b0011) || (sel_be == 4'b1111);
   assign legal    = in_range && (sel_rw_ || be_ok);

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state       <= IDLE;
         grant       <= 1'b0;
         ptr         <= 1'b0;
         err_flag    <= 1'b0;
         ack0        <= 1'b0;
         ack1        <= 1'b0;
         err_o       <= 1'b0;
         rdata_o     <= '0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         mem_rw_     <= 1'b1;
         mem_byte_en <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  grant       <= sel;
                  ptr         <= ~sel;
                  mem_addr    <= sel_addr;
                  mem_wdata   <= sel_wdata;
                  mem_byte_en <= sel_be;
                  // An illegal access is turned into a read so memory is never written.
                  mem_rw_     <= sel_rw_ | ~legal;
                  err_flag    <= ~legal;
                  state       <= ACCESS;
               end
            end
            ACCESS: begin
               rdata_o <= (mem_rw_ && !err_flag) ? mem_rdata : '0;
               err_o   <= err_flag;
               ack0    <= ~grant;
               ack1    <= grant;
               mem_rw_ <= 1'b1;
               state   <= RESP;
            end
            RESP: begin
               ack0  <= 1'b0;
               ack1  <= 1'b0;
               err_o <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef DMEM_ARB_STATS_EN
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         gnt_cnt0 <= '0;
         gnt_cnt1 <= '0;
         err_cnt  <= '0;
      end else if (state == IDLE && any_req) begin
         if (!sel && gnt_cnt0 != 16'hFFFF) gnt_cnt0 <= gnt_cnt0 + 16'd1;
         if (sel && gnt_cnt1 != 16'hFFFF)  gnt_cnt1 <= gnt_cnt1 + 16'd1;
         if (!legal && err_cnt != 8'hFF)   err_cnt  <= err_cnt + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

   typedef struct {
      int          port;
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_ = 1'b1;
   logic        req0 = 1'b0, req1 = 1'b0;
   logic        rw0_ = 1'b1, rw1_ = 1'b1;
   logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
   logic [3:0]  be0 = '0, be1 = '0;
   logic        ack0, ack1, err_o, mem_rw_;
   logic [31:0] rdata_o, mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_byte_en;
`ifdef DMEM_ARB_STATS_EN
   logic [15:0] gnt_cnt0, gnt_cnt1;
   logic [7:0]  err_cnt;
`endif

   logic [31:0] mem [0:1023];
   logic [31:0] ref_mem [0:1023];
   logic        poke_en = 1'b0;
   logic [9:0]  poke_idx = '0;
   logic [31:0] poke_val = '0;
   logic        mem_in;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   dmem_arbiter dut (
      .clk(clk), .rst_(rst_),
      .req0(req0), .req1(req1), .rw0_(rw0_), .rw1_(rw1_),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .be0(be0), .be1(be1), .ack0(ack0), .ack1(ack1),
      .rdata_o(rdata_o), .err_o(err_o),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rw_(mem_rw_),
      .mem_byte_en(mem_byte_en),
`ifdef DMEM_ARB_STATS_EN
      .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1), .err_cnt(err_cnt),
`endif
      .mem_rdata(mem_rdata)
   );

   // Attached memory: combinational read, posedge byte-enabled write.
   assign mem_in = (mem_addr >= 32'h1000) && (mem_addr < 32'h1400);

   always_comb begin
      mem_rdata = '0;
      if (mem_in) mem_rdata = mem[mem_addr[9:0]];
   end

   always @(posedge clk) begin
      if (poke_en) mem[poke_idx] <= poke_val;
      else if (!mem_rw_ && mem_in) begin
         for (int b = 0; b < 4; b++)
            if (mem_byte_en[b]) mem[mem_addr[9:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic poke(input int idx, input logic [31:0] val);
      @(negedge clk);
      poke_en  = 1'b1;
      poke_idx = 10'(idx);
      poke_val = val;
      ref_mem[idx] = val;
      @(negedge clk);
      poke_en = 1'b0;
   endtask

   // Reference behaviour of one transaction; updates the shadow memory.
   task automatic push_exp(input int port, input logic rw_, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [3:0] be);
      exp_t e;
      logic ok;
      int   idx;
      idx = int'(addr[9:0]);
      ok  = (addr >= 32'h1000) && (addr < 32'h1400) &&
            (rw_ || (be inside {4'b0001, 4'b0011, 4'b1111}));
      e.port  = port;
      e.err   = !ok;
      e.rdata = (ok && rw_) ? ref_mem[idx] : 32'h0;
      if (ok && !rw_)
         for (int b = 0; b < 4; b++)
            if (be[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
      sb.push_back(e);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      req0 = 1'b0;
      req1 = 1'b0;
      rst_ = 1'b0;
      repeat (2) @(negedge clk);
      rst_ = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_ = 1'b0;
      #1;
      total++; if (ack0 !== 1'b0) begin bad++; $display("FAIL reset ack0: got %b want 0", ack0); end
      total++; if (ack1 !== 1'b0) begin bad++; $display("FAIL reset ack1: got %b want 0", ack1); end
      total++; if (err_o !== 1'b0) begin bad++; $display("FAIL reset err_o: got %b want 0", err_o); end
      total++; if (rdata_o !== 32'h0) begin bad++; $display("FAIL reset rdata_o: got %h want 0", rdata_o); end
      total++; if (mem_rw_ !== 1'b1) begin bad++; $display("FAIL reset mem_rw_: got %b want 1", mem_rw_); end
      total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL reset mem_addr: got %h want 0", mem_addr); end
      total++; if (mem_wdata !== 32'h0) begin bad++; $display("FAIL reset mem_wdata: got %h want 0", mem_wdata); end
      total++; if (mem_byte_en !== 4'h0) begin bad++; $display("FAIL reset mem_byte_en: got %h want 0", mem_byte_en); end
      repeat (2) @(negedge clk);
      rst_ = 1'b1;
      @(negedge clk);
      total++; if (ack0 !== 1'b0 || ack1 !== 1'b0) begin bad++; $display("FAIL idle acks: got %b%b want 00", ack0, ack1); end
   endtask

   // Single transaction on one port; checks latency, scoreboard result and write strobe.
   task automatic test_xact(input string name, input int port, input logic rw_,
                            input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be);
      exp_t e;
      logic got, both, obs_err;
      int   obs_port, lat, rwlow, want_low;
      logic [31:0] obs_rdata;
      @(negedge clk);
      if (port == 0) begin
         rw0_ = rw_; addr0 = addr; wdata0 = wd; be0 = be; req0 = 1'b1;
      end else begin
         rw1_ = rw_; addr1 = addr; wdata1 = wd; be1 = be; req1 = 1'b1;
      end
      push_exp(port, rw_, addr, wd, be);
      got = 0; both = 0; lat = 0; rwlow = 0; obs_port = -1; obs_err = 0; obs_rdata = '0;
      while (!got && lat < 8) begin
         @(posedge clk); #1;
         lat++;
         if (mem_rw_ === 1'b0) rwlow++;
         if (ack0 || ack1) begin
            got = 1;
            both = ack0 && ack1;
            obs_port = ack1 ? 1 : 0;
            obs_err = err_o;
            obs_rdata = rdata_o;
         end
      end
      @(negedge clk);
      req0 = 1'b0;
      req1 = 1'b0;
      e = sb.pop_front();
      want_low = (e.err || rw_) ? 0 : 1;
      total++;
      if (!got) begin
         bad++; $display("FAIL %s ack timeout: no ack within %0d cycles", name, lat);
      end else begin
         total++; if (obs_port != e.port) begin bad++; $display("FAIL %s ack port: got %0d want %0d", name, obs_port, e.port); end
         total++; if (both) begin bad++; $display("FAIL %s both acks: got 1 want 0", name); end
         total++; if (obs_err !== e.err) begin bad++; $display("FAIL %s err_o: got %b want %b", name, obs_err, e.err); end
         total++; if (obs_rdata !== e.rdata) begin bad++; $display("FAIL %s rdata_o: got %h want %h", name, obs_rdata, e.rdata); end
         total++; if (lat != 2) begin bad++; $display("FAIL %s latency: got %0d want 2", name, lat); end
         total++; if (rwlow != want_low) begin bad++; $display("FAIL %s mem_rw_ low cycles: got %0d want %0d", name, rwlow, want_low); end
      end
   endtask

   // Both ports hold read requests; acks must alternate from port 0, one per 3 cycles.
   task automatic test_contention(input int n);
      exp_t e;
      int   cyc, last, seen, want_gap, obs_port;
      logic both_seen;
      for (int i = 0; i < n; i++)
         push_exp(i % 2, 1'b1, (i % 2) ? 32'h1020 : 32'h1010, 32'h0, 4'hF);
      @(negedge clk);
      rw0_ = 1'b1; addr0 = 32'h1010; be0 = 4'hF; req0 = 1'b1;
      rw1_ = 1'b1; addr1 = 32'h1020; be1 = 4'hF; req1 = 1'b1;
      cyc = 0; last = 0; seen = 0; both_seen = 0;
      while (seen < n && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
         if (ack0 && ack1) both_seen = 1;
         if (ack0 || ack1) begin
            e = sb.pop_front();
            obs_port = ack1 ? 1 : 0;
            want_gap = (seen == 0) ? 2 : 3;
            total++; if (obs_port != e.port) begin bad++; $display("FAIL contention ack %0d port: got %0d want %0d", seen, obs_port, e.port); end
            total++; if (rdata_o !== e.rdata) begin bad++; $display("FAIL contention ack %0d rdata_o: got %h want %h", seen, rdata_o, e.rdata); end
            total++; if (cyc - last != want_gap) begin bad++; $display("FAIL contention ack %0d spacing: got %0d want %0d", seen, cyc - last, want_gap); end
            last = cyc;
            seen++;
            if (seen == n) begin
               @(negedge clk);
               req0 = 1'b0;
               req1 = 1'b0;
            end
         end
      end
      total++;
      if (seen < n) begin
         bad++; $display("FAIL contention timeout: got %0d acks want %0d", seen, n);
         @(negedge clk);
         req0 = 1'b0;
         req1 = 1'b0;
         while (sb.size() > 0) void'(sb.pop_front());
      end
      total++; if (both_seen) begin bad++; $display("FAIL contention both acks: got 1 want 0"); end
   endtask

   task automatic test_reset_mid_write();
      poke(12, 32'h5);
      @(negedge clk);
      rw0_ = 1'b0; addr0 = 32'h100C; wdata0 = 32'hFFFF_FFFF; be0 = 4'hF; req0 = 1'b1;
      @(posedge clk); #1;
      total++; if (mem_rw_ !== 1'b0) begin bad++; $display("FAIL midwr access mem_rw_: got %b want 0", mem_rw_); end
      #2;
      rst_ = 1'b0;
      #1;
      total++; if (mem_rw_ !== 1'b1) begin bad++; $display("FAIL midwr reset mem_rw_: got %b want 1", mem_rw_); end
      req0 = 1'b0;
      @(posedge clk); #1;
      total++; if (ack0 !== 1'b0) begin bad++; $display("FAIL midwr ack0: got %b want 0", ack0); end
      total++; if (mem[12] !== 32'h5) begin bad++; $display("FAIL midwr word: got %h want 00000005", mem[12]); end
      @(negedge clk);
      rst_ = 1'b1;
      test_contention(2);
   endtask

   task automatic test_byte_write();
      poke(8, 32'h1122_3344);
      test_xact("bwr", 1, 1'b0, 32'h1008, 32'hAABB_CCDD, 4'b0001);
      test_xact("brd", 1, 1'b1, 32'h1008, 32'h0, 4'hF);
      total++; if (mem[8] !== 32'h1122_33DD) begin bad++; $display("FAIL byte word: got %h want 112233dd", mem[8]); end
      test_xact("hwr", 0, 1'b0, 32'h1008, 32'h0000_5566, 4'b0011);
      test_xact("hrd", 0, 1'b1, 32'h1008, 32'h0, 4'hF);
   endtask

   task automatic test_illegal();
      test_xact("wr_low", 0, 1'b0, 32'h0FFC, 32'h1234_5678, 4'hF);
      poke(0, 32'h1234_5678);
      test_xact("wr_be0111", 1, 1'b0, 32'h1000, 32'hFFFF_FFFF, 4'b0111);
      total++; if (mem[0] !== 32'h1234_5678) begin bad++; $display("FAIL be0111 word: got %h want 12345678", mem[0]); end
      test_xact("wr_be0000", 0, 1'b0, 32'h1000, 32'hFFFF_FFFF, 4'b0000);
      test_xact("rd_high", 0, 1'b1, 32'h1400, 32'h0, 4'hF);
      poke(1023, 32'hCAFE_F00D);
      test_xact("rd_last", 1, 1'b1, 32'h13FF, 32'h0, 4'hF);
      test_xact("rd_base", 0, 1'b1, 32'h1000, 32'h0, 4'hF);
   endtask

`ifdef DMEM_ARB_STATS_EN
   task automatic test_stats();
      apply_reset();
      test_xact("st0a", 0, 1'b1, 32'h1010, 32'h0, 4'hF);
      test_xact("st1a", 1, 1'b1, 32'h1020, 32'h0, 4'hF);
      test_xact("st0b", 0, 1'b0, 32'h0FFC, 32'h0, 4'hF);
      test_xact("st1b", 1, 1'b1, 32'h1010, 32'h0, 4'hF);
      test_xact("st0c", 0, 1'b1, 32'h1020, 32'h0, 4'hF);
      total++; if (gnt_cnt0 !== 16'd3) begin bad++; $display("FAIL gnt_cnt0: got %0d want 3", gnt_cnt0); end
      total++; if (gnt_cnt1 !== 16'd2) begin bad++; $display("FAIL gnt_cnt1: got %0d want 2", gnt_cnt1); end
      total++; if (err_cnt !== 8'd1) begin bad++; $display("FAIL err_cnt: got %0d want 1", err_cnt); end
   endtask
`endif

   initial begin
      for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
      test_reset();
      poke(16, 32'h0101_1010);
      poke(32, 32'h0202_2020);
      test_contention(4);
      test_xact("wr1004", 0, 1'b0, 32'h1004, 32'hDEAD_BEEF, 4'hF);
      test_xact("rd1004", 0, 1'b1, 32'h1004, 32'h0, 4'hF);
      test_byte_write();
      test_illegal();
      test_reset_mid_write();
`ifdef DMEM_ARB_STATS_EN
      test_stats();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-requester controller that shares the single-port data memory (combinational read, posedge write, rw_ read=1/write=0, 4-bit byte enables) between the CPU load/store unit (port 0) and a DMA/debug master (port 1). Round-robin arbitration, req/ack handshake per port, registered memory-side drive, and range/byte-enable legality checking with an error flag. Sits between the CPU/DMA masters and the data memory instance.

Parameters:
WORDS, 1024, number of words in the attached memory
BITS, 32, data and address width
BASE_ADDR, 32'h1000, first valid address; valid window is BASE_ADDR to BASE_ADDR+WORDS-1

Ports:
clk  in  1  system clock
rst_  in  1  asynchronous active-low reset
req0, req1  in  1 each  request; held with its fields stable until the matching ack
rw0_, rw1_  in  1 each  1=read, 0=write
addr0, addr1  in  BITS each  byte/word address as used by memory
wdata0, wdata1  in  BITS each  write data
be0, be1  in  4 each  byte enables
ack0, ack1  out  1 each  one-cycle completion pulse
rdata_o  out  BITS  read data, valid in the ack cycle
err_o  out  1  qualifies ack: access was illegal and suppressed
mem_addr  out  BITS  to memory addr
mem_wdata  out  BITS  to memory wdata
mem_rw_  out  1  to memory rw_
mem_byte_en  out  4  to memory byte_en
mem_rdata  in  BITS  from memory rdata

Behaviour:
- FSM states: IDLE, ACCESS, RESP. Reset state IDLE.
- Reset values: ack0=ack1=0, err_o=0, rdata_o=0, mem_rw_=1, mem_addr=0, mem_wdata=0, mem_byte_en=0, grant=0, priority pointer=port 0.
- Reset is asynchronous. Asserting it in any state returns the FSM to IDLE and forces mem_rw_=1 at once, so an in-flight write is never committed.
- IDLE:
  - No req: stay in IDLE.
  - One req: grant it.
  - Both: grant the port named by the priority pointer.
  - At the edge, latch the granted port's addr/wdata/be/rw_ into the mem_* registers, record the grant, and go to ACCESS.
  - Set the pointer to the other port after every grant.
- Legality is checked at the latch edge:
  - Illegal if addr is outside [BASE_ADDR, BASE_ADDR+WORDS).
  - Illegal if it is a write with be not in {0001, 0011, 1111}.
  - An illegal access sets an internal err flag and latches mem_rw_=1, so memory is never written.
- ACCESS, one cycle:
  - mem_* are driven with the latched values.
  - A legal write commits in memory at the edge ending ACCESS.
  - At that edge: rdata_o <= mem_rdata for a legal read; rdata_o <= 0 for a write or an illegal access. err_o <= err flag; ack of the granted port <= 1; mem_rw_ <= 1. Go to RESP.
- RESP, one cycle:
  - ack high for the granted port only; rdata_o and err_o valid.
  - Requests are ignored in RESP. At the edge: ack <= 0, err_o <= 0, go to IDLE.
  - rdata_o holds its value until the next ack.
- Latency: req seen in IDLE to ack = 2 cycles. Throughput: one access per 3 cycles.
- A requester may present a new transaction at the edge on which it samples ack; that request is arbitrated in the following IDLE.
- req dropped before ack: undefined, not supported. The latched transaction still completes and is acked.
- mem_rw_ is 0 only during ACCESS of a legal write.

Optional Feature:
Macro DMEM_ARB_STATS_EN.
- Defined: adds outputs gnt_cnt0 and gnt_cnt1 (16 bits each) and err_cnt (8 bits).
  - Each is a saturating count, reset to 0 by rst_.
  - gnt_cnt increments on each grant edge of its port.
  - err_cnt increments on each illegal access.
  - All three stick at all-ones.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Single write then read: port0 write addr=32'h1004, wdata=32'hDEADBEEF, be=1111, then read 32'h1004 -> ack0 two cycles after each req; read has rdata_o=32'hDEADBEEF, err_o=0; mem_rw_ low exactly one cycle.
- Byte write: preload 32'h11223344 at 32'h1008, port1 write wdata=32'hAABBCCDD, be=0001, then read -> rdata_o=32'h112233DD.
- Contention: req0 and req1 both held continuously, reads of 32'h1010 and 32'h1020 -> acks alternate 0,1,0,1 starting with port 0 after reset, one ack every 3 cycles, never both acks in the same cycle.
- Illegal accesses:
  - write to 32'h0FFC -> ack with err_o=1, mem_rw_ stays 1.
  - write be=0111 to 32'h1000 -> err_o=1, word unchanged.
  - read 32'h1400 -> err_o=1, rdata_o=0.
- Reset mid-write: assert rst_=0 while in ACCESS of a write to 32'h100C (old value 32'h5) -> mem_rw_=1 immediately, no ack, word still 32'h5; after release the FSM is in IDLE and port 0 has priority.
- DMEM_ARB_STATS_EN: 3 port0 grants, 2 port1 grants, 1 error -> gnt_cnt0=3, gnt_cnt1=2, err_cnt=1.
